// File: rtl/pong_if.sv
// Game-engine signal bundle between the sync generator / player controls and the VGA DAC.
// master drives video timing and controls; slave is the engine.
interface pong_if;
  logic        iFRAME;
  logic [10:0] iXPOS;
  logic [9:0]  iYPOS;
  logic        iBLANK_n;
  logic        iP1_UP, iP1_DN, iP2_UP, iP2_DN;
  logic [1:0]  iAUTO;
  logic        iSTART;
  logic [3:0]  oVGA_R, oVGA_G, oVGA_B;
  logic [3:0]  oSCORE1, oSCORE2;
  logic [1:0]  oSTATE;

  modport master (
    output iFRAME, iXPOS, iYPOS, iBLANK_n, iP1_UP, iP1_DN, iP2_UP, iP2_DN, iAUTO, iSTART,
    input  oVGA_R, oVGA_G, oVGA_B, oSCORE1, oSCORE2, oSTATE
  );
  modport slave (
    input  iFRAME, iXPOS, iYPOS, iBLANK_n, iP1_UP, iP1_DN, iP2_UP, iP2_DN, iAUTO, iSTART,
    output oVGA_R, oVGA_G, oVGA_B, oSCORE1, oSCORE2, oSTATE
  );
endinterface

// File: rtl/pong_engine.sv
// Pong game engine: per-frame ball/paddle/score/state update plus a registered
// pixel colour generator with one cycle of latency.
module pong_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int FIELD_TOP    = 60,
  parameter int FIELD_BOT    = 468,
  parameter int BALL_SIZE    = 12,
  parameter int PADDLE_H     = 60,
  parameter int PADDLE_W     = 10,
  parameter int P1_X         = 50,
  parameter int P2_X         = 580,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input logic   iVGA_CLK,
  input logic   iRST,
  pong_if.slave bus
);
  typedef logic signed [11:0] s12_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_e;

  localparam int   CW   = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam s12_t XS   = s12_t'((H_ACTIVE - BALL_SIZE) / 2);
  localparam s12_t YS   = s12_t'((FIELD_TOP + FIELD_BOT - BALL_SIZE) / 2);
  localparam s12_t PY0  = s12_t'((FIELD_TOP + FIELD_BOT - PADDLE_H) / 2);
  localparam s12_t FT   = s12_t'(FIELD_TOP);
  localparam s12_t FB   = s12_t'(FIELD_BOT);
  localparam s12_t WT0  = s12_t'(FIELD_TOP - 3);
  localparam s12_t WB1  = s12_t'(FIELD_BOT + 3);
  localparam s12_t BS   = s12_t'(BALL_SIZE);
  localparam s12_t PH   = s12_t'(PADDLE_H);
  localparam s12_t P1L  = s12_t'(P1_X);
  localparam s12_t P1R  = s12_t'(P1_X + PADDLE_W);
  localparam s12_t P2L  = s12_t'(P2_X);
  localparam s12_t P2R  = s12_t'(P2_X + PADDLE_W);
  localparam s12_t SP   = s12_t'(BALL_SPEED);
  localparam s12_t PS   = s12_t'(PADDLE_SPEED);
  localparam s12_t HA   = s12_t'(H_ACTIVE);
  localparam s12_t VA   = s12_t'(V_ACTIVE);
  localparam s12_t PMAX = s12_t'(FIELD_BOT - PADDLE_H);
  localparam s12_t HB   = s12_t'(BALL_SIZE / 2);
  localparam s12_t HP   = s12_t'(PADDLE_H / 2);
  localparam s12_t DX0  = s12_t'(H_ACTIVE / 2 - 1);
  localparam s12_t DX1  = s12_t'(H_ACTIVE / 2);

  state_e          state_q, state_d;
  logic [3:0]      score1_q, score1_d, score2_q, score2_d;
  s12_t            bx_q, bx_d, by_q, by_d, p1y_q, p1y_d, p2y_q, p2y_d;
  logic            dxp_q, dxp_d, dyp_q, dyp_d;  // 1 = moving toward +x / +y
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [11:0]     rgb_q, rgb_d;

  // Auto mode chases the ball centre; manual mode follows the buttons.
  function automatic s12_t pad_next(input s12_t py, input logic up, input logic dn,
                                    input logic aut, input s12_t ball_y);
    s12_t diff, step, ny;
    diff = (ball_y + HB) - (py + HP);
    if (aut)             step = (diff > PS) ? PS : ((diff < -PS) ? -PS : diff);
    else if (up && !dn)  step = -PS;
    else if (dn && !up)  step = PS;
    else                 step = '0;
    ny = py + step;
    if (ny < FT)         ny = FT;
    else if (ny > PMAX)  ny = PMAX;
    return ny;
  endfunction

  logic ov1, ov2, hit1, hit2, top, bot, miss_l, miss_r, dx_ref, dy_ref;
  s12_t bx_mv, by_mv, p1_nxt, p2_nxt;

  assign ov1    = (bx_q < P1R) && (P1L < bx_q + BS) && (by_q < p1y_q + PH) && (p1y_q < by_q + BS);
  assign ov2    = (bx_q < P2R) && (P2L < bx_q + BS) && (by_q < p2y_q + PH) && (p2y_q < by_q + BS);
  assign hit1   = ov1 && !dxp_q;
  assign hit2   = ov2 && dxp_q;
  assign top    = by_q <= FT + SP;
  assign bot    = by_q + BS >= FB - SP;
  assign miss_l = (bx_q <= SP) && !hit1;
  assign miss_r = (bx_q + BS >= HA - SP) && !hit2;
  assign dx_ref = hit1 | (dxp_q & ~hit2);
  assign dy_ref = top | (dyp_q & ~bot);
  assign bx_mv  = dx_ref ? bx_q + SP : bx_q - SP;
  assign by_mv  = dy_ref ? by_q + SP : by_q - SP;
  assign p1_nxt = pad_next(p1y_q, bus.iP1_UP, bus.iP1_DN, bus.iAUTO[0], by_q);
  assign p2_nxt = pad_next(p2y_q, bus.iP2_UP, bus.iP2_DN, bus.iAUTO[1], by_q);

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dxp_d    = dxp_q;
    dyp_d    = dyp_q;
    p1y_d    = p1y_q;
    p2y_d    = p2y_q;
    cnt_d    = cnt_q;
    if (bus.iFRAME) begin
      case (state_q)
        S_IDLE: if (bus.iSTART) begin
          score1_d = '0;
          score2_d = '0;
          state_d  = S_SERVE;
        end
        S_SERVE: begin
          p1y_d = p1_nxt;
          p2y_d = p2_nxt;
          bx_d  = XS;
          by_d  = YS;
          if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
            cnt_d   = '0;
            dyp_d   = ~dyp_q;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PLAY: begin
          p1y_d = p1_nxt;
          p2y_d = p2_nxt;
          dxp_d = dx_ref;
          dyp_d = dy_ref;
          bx_d  = bx_mv;
          by_d  = by_mv;
          // Serve goes toward the player who just lost the point.
          if (miss_l) begin
            score2_d = score2_q + 4'd1;
            dxp_d    = 1'b0;
            if (score2_q + 4'd1 == 4'(WIN_SCORE)) state_d = S_OVER;
            else begin state_d = S_SERVE; bx_d = XS; by_d = YS; end
          end else if (miss_r) begin
            score1_d = score1_q + 4'd1;
            dxp_d    = 1'b1;
            if (score1_q + 4'd1 == 4'(WIN_SCORE)) state_d = S_OVER;
            else begin state_d = S_SERVE; bx_d = XS; by_d = YS; end
          end
        end
        S_OVER: if (bus.iSTART) begin
          score1_d = '0;
          score2_d = '0;
          p1y_d    = PY0;
          p2y_d    = PY0;
          bx_d     = XS;
          by_d     = YS;
          state_d  = S_SERVE;
        end
      endcase
    end
  end

  s12_t       px, py;
  logic [9:0] ydiff;
  logic       in_p1, in_p2, in_ball, in_wall, in_dash;

  always_comb begin
    px      = s12_t'({1'b0, bus.iXPOS});
    py      = s12_t'({2'b00, bus.iYPOS});
    ydiff   = bus.iYPOS - 10'(FIELD_TOP);
    in_p1   = (px >= P1L) && (px < P1R) && (py >= p1y_q) && (py < p1y_q + PH);
    in_p2   = (px >= P2L) && (px < P2R) && (py >= p2y_q) && (py < p2y_q + PH);
    in_ball = ((state_q == S_SERVE) || (state_q == S_PLAY)) &&
              (px >= bx_q) && (px < bx_q + BS) && (py >= by_q) && (py < by_q + BS);
    in_wall = ((py >= WT0) && (py < FT)) || ((py >= FB) && (py < WB1));
    in_dash = ((px == DX0) || (px == DX1)) && (py >= FT) && (py < FB) &&
              ((ydiff % 10'd20) < 10'd10);
    rgb_d   = 12'h000;
    if (bus.iBLANK_n && (px < HA) && (py < VA)) begin
      if (in_p1)        rgb_d = 12'hF0F;
      else if (in_p2)   rgb_d = 12'h0FF;
      else if (in_ball) rgb_d = 12'hFFF;
      else if (in_wall) rgb_d = 12'h0F0;
      else if (in_dash) rgb_d = 12'hFFF;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      score1_q <= '0;
      score2_q <= '0;
      bx_q     <= XS;
      by_q     <= YS;
      dxp_q    <= 1'b1;
      dyp_q    <= 1'b1;
      p1y_q    <= PY0;
      p2y_q    <= PY0;
      cnt_q    <= '0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dxp_q    <= dxp_d;
      dyp_q    <= dyp_d;
      p1y_q    <= p1y_d;
      p2y_q    <= p2y_d;
      cnt_q    <= cnt_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.oVGA_R  = rgb_q[11:8];
  assign bus.oVGA_G  = rgb_q[7:4];
  assign bus.oVGA_B  = rgb_q[3:0];
  assign bus.oSCORE1 = score1_q;
  assign bus.oSCORE2 = score2_q;
  assign bus.oSTATE  = state_q;
endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: directed game phases with random controls and random
// pixel probes, checked against a frame-level integer model of the game rules.
module tb_pong_engine;
  localparam int HA = 640, FT = 60, FB = 468, BS = 12, PH = 60, PW = 10;
  localparam int P1X = 50, P2X = 580, SP = 2, PS = 4, WIN = 9, SF = 60;
  localparam int XS = 314, YS = 258, PY0 = 234;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pong_if bus();

  pong_engine dut (.iVGA_CLK(clk), .iRST(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 serve, 2 play, 3 over; velocities are signed ints.
  int m_st, m_s1, m_s2, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_s1 = 0; m_s2 = 0; m_bx = XS; m_by = YS;
    m_dx = SP; m_dy = SP; m_p1 = PY0; m_p2 = PY0; m_cnt = 0;
  endfunction

  function automatic int overlap(input int bx, input int by, input int px, input int py);
    return int'((bx < px + PW) && (px < bx + BS) && (by < py + PH) && (py < by + BS));
  endfunction

  function automatic int paddle(input int py, input bit up, input bit dn, input bit aut);
    int d, n;
    if (aut) begin
      d = (m_by + BS / 2) - (py + PH / 2);
      if (d > PS) d = PS;
      if (d < -PS) d = -PS;
    end else d = (up == dn) ? 0 : (up ? -PS : PS);
    n = py + d;
    if (n < FT) n = FT;
    if (n > FB - PH) n = FB - PH;
    return n;
  endfunction

  function automatic void model_frame();
    int np1, np2, h1, h2, ndx, ndy, nbx, nby;
    np1 = paddle(m_p1, bus.iP1_UP, bus.iP1_DN, bus.iAUTO[0]);
    np2 = paddle(m_p2, bus.iP2_UP, bus.iP2_DN, bus.iAUTO[1]);
    case (m_st)
      0: if (bus.iSTART) begin m_s1 = 0; m_s2 = 0; m_st = 1; end
      1: begin
        m_p1 = np1; m_p2 = np2; m_bx = XS; m_by = YS;
        if (m_cnt == SF - 1) begin m_cnt = 0; m_dy = -m_dy; m_st = 2; end
        else m_cnt++;
      end
      2: begin
        h1 = overlap(m_bx, m_by, P1X, m_p1) & int'(m_dx < 0);
        h2 = overlap(m_bx, m_by, P2X, m_p2) & int'(m_dx > 0);
        ndx = h1 ? SP : (h2 ? -SP : m_dx);
        ndy = (m_by <= FT + SP) ? SP : ((m_by + BS >= FB - SP) ? -SP : m_dy);
        nbx = m_bx + ndx;
        nby = m_by + ndy;
        if (m_bx <= SP && !h1) begin
          m_s2++; ndx = -SP;
          if (m_s2 == WIN) m_st = 3; else begin m_st = 1; nbx = XS; nby = YS; end
        end else if (m_bx + BS >= HA - SP && !h2) begin
          m_s1++; ndx = SP;
          if (m_s1 == WIN) m_st = 3; else begin m_st = 1; nbx = XS; nby = YS; end
        end
        m_dx = ndx; m_dy = ndy; m_bx = nbx; m_by = nby; m_p1 = np1; m_p2 = np2;
      end
      default: if (bus.iSTART) begin
        m_s1 = 0; m_s2 = 0; m_p1 = PY0; m_p2 = PY0; m_bx = XS; m_by = YS; m_st = 1;
      end
    endcase
  endfunction

  function automatic logic [11:0] exp_rgb(input int x, input int y, input bit bl);
    if (!bl) return 12'h000;
    if (x >= P1X && x < P1X + PW && y >= m_p1 && y < m_p1 + PH) return 12'hF0F;
    if (x >= P2X && x < P2X + PW && y >= m_p2 && y < m_p2 + PH) return 12'h0FF;
    if ((m_st == 1 || m_st == 2) && x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS)
      return 12'hFFF;
    if ((y >= FT - 3 && y < FT) || (y >= FB && y < FB + 3)) return 12'h0F0;
    if ((x == HA / 2 - 1 || x == HA / 2) && y >= FT && y < FB && ((y - FT) % 20) < 10)
      return 12'hFFF;
    return 12'h000;
  endfunction

  task automatic pix(input string tag, input int x, input int y, input bit bl);
    logic [11:0] e;
    bus.iXPOS = 11'(x); bus.iYPOS = 10'(y); bus.iBLANK_n = bl;
    e = exp_rgb(x, y, bl);
    @(negedge clk);
    chk(tag, {bus.oVGA_R, bus.oVGA_G, bus.oVGA_B}, {20'd0, e});
  endtask

  // Probes are aimed at object edges most of the time so off-by-one errors show.
  task automatic pix_rand();
    int x, y;
    case ($urandom_range(0, 5))
      0: begin x = m_bx + int'($urandom_range(0, 15)) - 2; y = m_by + int'($urandom_range(0, 15)) - 2; end
      1: begin x = P1X + int'($urandom_range(0, 11)) - 1; y = m_p1 + int'($urandom_range(0, 63)) - 2; end
      2: begin x = P2X + int'($urandom_range(0, 11)) - 1; y = m_p2 + int'($urandom_range(0, 63)) - 2; end
      3: begin x = int'($urandom_range(0, 639)); y = $urandom_range(0, 1) ? int'($urandom_range(55, 61)) : int'($urandom_range(466, 472)); end
      4: begin x = int'($urandom_range(317, 322)); y = int'($urandom_range(55, 472)); end
      default: begin x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479)); end
    endcase
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    pix("rgb_rand", x, y, $urandom_range(0, 7) != 0);
  endtask

  task automatic frame(input bit start);
    bus.iFRAME = 1'b1; bus.iSTART = start;
    @(negedge clk);
    model_frame();
    bus.iFRAME = 1'b0; bus.iSTART = 1'b0;
    chk("state", {30'd0, bus.oSTATE}, m_st);
    chk("score1", {28'd0, bus.oSCORE1}, m_s1);
    chk("score2", {28'd0, bus.oSCORE2}, m_s2);
    pix_rand();
    pix_rand();
  endtask

  task automatic rand_ctrl();
    bus.iP1_UP = $urandom_range(0, 1); bus.iP1_DN = $urandom_range(0, 1);
    bus.iP2_UP = $urandom_range(0, 1); bus.iP2_DN = $urandom_range(0, 1);
  endtask

  initial begin
    int s1_save, s2_save, n;
    bus.iFRAME = 0; bus.iXPOS = 11'd55; bus.iYPOS = 10'd250; bus.iBLANK_n = 1;
    bus.iP1_UP = 0; bus.iP1_DN = 0; bus.iP2_UP = 0; bus.iP2_DN = 0;
    bus.iAUTO = 2'd0; bus.iSTART = 0;
    repeat (3) @(negedge clk);
    chk("reset_rgb", {bus.oVGA_R, bus.oVGA_G, bus.oVGA_B}, 0);
    chk("reset_state", {30'd0, bus.oSTATE}, 0);
    chk("reset_scores", {bus.oSCORE1, bus.oSCORE2}, 0);
    rst = 1'b0;
    model_reset();

    repeat (3) frame(1'b0);
    pix("idle_paddle1", 55, 250, 1'b1);
    pix("idle_no_ball", 316, 262, 1'b1);

    frame(1'b1);
    chk("start_serve", {30'd0, bus.oSTATE}, 1);
    pix("serve_ball", 316, 262, 1'b1);
    pix("serve_ball_edge", 325, 269, 1'b1);
    pix("serve_ball_out", 326, 262, 1'b1);
    pix("p1_pixel", 55, 250, 1'b1);
    pix("p1_blank", 55, 250, 1'b0);
    repeat (60) frame(1'b0);
    chk("play_after_serve", {30'd0, bus.oSTATE}, 2);
    frame(1'b1);  // start is ignored in PLAY
    pix("ball_moved", 316, 256, 1'b1);
    pix("ball_moved_left", 315, 260, 1'b1);

    // No paddle movement: first rally is lost on the right.
    n = 0;
    while (m_s1 == 0 && m_s2 == 0 && n < 400) begin frame(1'b0); n++; end
    chk("first_miss_score1", {28'd0, bus.oSCORE1}, 1);
    chk("first_miss_state", {30'd0, bus.oSTATE}, 1);
    pix("recentred", 316, 262, 1'b1);

    // Auto-tracking paddles never let the ball past.
    bus.iAUTO = 2'd3;
    s1_save = m_s1; s2_save = m_s2;
    repeat (600) begin rand_ctrl(); frame(1'b0); end
    chk("auto_hold_s1", {28'd0, bus.oSCORE1}, s1_save);
    chk("auto_hold_s2", {28'd0, bus.oSCORE2}, s2_save);

    // Random manual play until someone wins.
    bus.iAUTO = 2'd0;
    n = 0;
    while (m_st != 3 && n < 9000) begin rand_ctrl(); frame(1'b0); n++; end
    chk("reach_over", {30'd0, bus.oSTATE}, 3);
    chk("win_score", (m_s1 == WIN) ? {28'd0, bus.oSCORE1} : {28'd0, bus.oSCORE2}, WIN);
    repeat (3) begin rand_ctrl(); frame(1'b0); end
    pix("over_no_ball", m_bx + 2, m_by + 2, 1'b1);
    frame(1'b1);
    chk("restart_state", {30'd0, bus.oSTATE}, 1);
    chk("restart_scores", {bus.oSCORE1, bus.oSCORE2}, 0);
    pix("restart_p1", 55, PY0, 1'b1);
    repeat (10) begin rand_ctrl(); frame(1'b0); end

    // Reset in the middle of a frame.
    bus.iXPOS = 11'(P1X + 2); bus.iYPOS = 10'(m_p1 + 1); bus.iBLANK_n = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_rgb", {bus.oVGA_R, bus.oVGA_G, bus.oVGA_B}, 0);
    chk("midreset_state", {30'd0, bus.oSTATE}, 0);
    rst = 1'b0;
    model_reset();
    pix("after_reset_p1", 55, 250, 1'b1);
    pix("after_reset_p2", 585, 293, 1'b1);
    frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
